// File: rtl/neighbor_addr_gen.sv
// D2Q9 neighbour address generator: one accepted node -> nine (dir, addr) outputs, one per cycle at full out_ready.
// Optional NBR_BOUNCEBACK_EN macro: edge-crossing directions return the node itself with out_bounce set.
module neighbor_addr_gen #(
    parameter int GRID_DIM      = 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM*GRID_DIM)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] node_addr,
    input  logic [ADDRESS_WIDTH-1:0] node_col,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [3:0]               out_dir,
    output logic                     out_last,
    output logic                     out_bounce,
    output logic                     err_col
);

    localparam int                     LOG2 = $clog2(GRID_DIM);
    localparam logic [ADDRESS_WIDTH-1:0] MASK = ADDRESS_WIDTH'(GRID_DIM - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE  = ADDRESS_WIDTH'(1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] col_q, row_q;
    logic [3:0]               dir_q;
    logic                     err_q;
    logic                     accept, fire;
    logic                     dc_inc, dc_dec, dr_inc, dr_dec;
    logic [ADDRESS_WIDTH-1:0] dc_v, dr_v, col_sum, row_sum, wrap_addr, nbr_addr;
    logic                     nbr_bounce;

    assign accept = (state_q == IDLE) && in_valid;
    assign fire   = (state_q == EMIT) && out_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = EMIT;
            EMIT: if (out_ready && dir_q == 4'd8) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q <= '0;
            row_q <= '0;
            dir_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                col_q <= node_col & MASK;
                row_q <= (node_addr >> LOG2) & MASK;
                dir_q <= '0;
            end else if (fire && dir_q != 4'd8) begin
                dir_q <= dir_q + 4'd1;
            end
            // Sticky; the captured column is used regardless of the mismatch.
            if (accept && (node_col != (node_addr & MASK))) err_q <= 1'b1;
        end
    end

    always_comb begin
        dc_inc = 1'b0;
        dc_dec = 1'b0;
        dr_inc = 1'b0;
        dr_dec = 1'b0;
        case (dir_q)
            4'd1: dc_inc = 1'b1;
            4'd2: dr_inc = 1'b1;
            4'd3: dc_dec = 1'b1;
            4'd4: dr_dec = 1'b1;
            4'd5: begin dc_inc = 1'b1; dr_inc = 1'b1; end
            4'd6: begin dc_dec = 1'b1; dr_inc = 1'b1; end
            4'd7: begin dc_dec = 1'b1; dr_dec = 1'b1; end
            4'd8: begin dc_inc = 1'b1; dr_dec = 1'b1; end
            default: ;
        endcase
    end

    // -1 is all ones; the power-of-two mask turns the sum into the periodic wrap.
    always_comb begin
        dc_v      = dc_inc ? ONE : (dc_dec ? {ADDRESS_WIDTH{1'b1}} : '0);
        dr_v      = dr_inc ? ONE : (dr_dec ? {ADDRESS_WIDTH{1'b1}} : '0);
        col_sum   = (col_q + dc_v) & MASK;
        row_sum   = (row_q + dr_v) & MASK;
        wrap_addr = (row_sum << LOG2) | col_sum;
    end

`ifdef NBR_BOUNCEBACK_EN
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     cross;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    addr_q <= '0;
        else if (accept) addr_q <= node_addr;
    end

    always_comb begin
        cross = (dc_inc && col_q == MASK) || (dc_dec && col_q == '0) ||
                (dr_inc && row_q == MASK) || (dr_dec && row_q == '0);
        nbr_addr   = cross ? addr_q : wrap_addr;
        nbr_bounce = cross;
    end
`else
    always_comb begin
        nbr_addr   = wrap_addr;
        nbr_bounce = 1'b0;
    end
`endif

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == EMIT);
        out_dir    = out_valid ? dir_q : 4'd0;
        out_addr   = out_valid ? nbr_addr : '0;
        out_last   = out_valid && (dir_q == 4'd8);
        out_bounce = out_valid && nbr_bounce;
        err_col    = err_q;
    end

endmodule

// File: doc/neighbor_addr_gen.md
NEIGHBOR_ADDR_GEN -- requirements
Module: neighbor_addr_gen

Interface
REQ-001 Parameter GRID_DIM, default 16, lattice edge length in nodes; SHALL be a power of two, at least 4.
REQ-002 Parameter ADDRESS_WIDTH, default $clog2(GRID_DIM*GRID_DIM), node address width.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  node_addr/node_col valid.
REQ-006 in_ready  output  1  block can accept a node.
REQ-007 node_addr  input  ADDRESS_WIDTH  linear node index, row-major.
REQ-008 node_col  input  ADDRESS_WIDTH  column of node_addr, produced by the column stage.
REQ-009 out_valid  output  1  out_addr/out_dir valid.
REQ-010 out_ready  input  1  consumer accepts the current output.
REQ-011 out_addr  output  ADDRESS_WIDTH  D2Q9 neighbour address for out_dir.
REQ-012 out_dir  output  4  direction 0..8.
REQ-013 out_last  output  1  high with direction 8.
REQ-014 out_bounce  output  1  neighbour lies across the domain edge (see Configuration).
REQ-015 err_col  output  1  sticky column-mismatch flag.

Function
REQ-016 Two states SHALL exist: IDLE and EMIT.
REQ-017 IDLE: in_ready=1 and out_valid=0; on in_valid the block SHALL capture node_addr, node_col and row=node_addr>>log2(GRID_DIM), set dir=0, and enter EMIT.
REQ-018 EMIT: in_ready=0 and out_valid=1; out_addr and out_dir SHALL come from registered state only.
REQ-019 First out_valid SHALL occur the cycle after input acceptance.
REQ-020 On out_valid&&out_ready: dir<8 advances dir; dir==8 returns to IDLE. Throughput SHALL be one node per 10 cycles at full out_ready.
REQ-021 Outputs SHALL hold stable while out_valid&&!out_ready.
REQ-022 Direction offsets (dc,dr): 0 (0,0), 1 E (+1,0), 2 N (0,+1), 3 W (-1,0), 4 S (0,-1), 5 NE (+1,+1), 6 NW (-1,+1), 7 SW (-1,-1), 8 SE (+1,-1).
REQ-023 out_addr SHALL equal ((row+dr) mod GRID_DIM)*GRID_DIM + ((col+dc) mod GRID_DIM), computed with ADDRESS_WIDTH arithmetic and no divider.
REQ-024 If node_col != node_addr mod GRID_DIM at acceptance, err_col SHALL set and stay set until reset. The captured node_col is still used.
REQ-025 in_valid SHALL be ignored while in EMIT.

Reset
REQ-026 Reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_last=0, out_bounce=0, out_addr=0, out_dir=0, err_col=0.
REQ-027 Reset during EMIT SHALL abandon the node. No further outputs for it SHALL appear after release.
REQ-028 The first cycle after release SHALL accept in_valid.

Configuration
REQ-029 Macro NBR_BOUNCEBACK_EN. When defined, any direction whose neighbour crosses a domain edge SHALL output out_addr=node_addr and out_bounce=1; other directions SHALL output out_bounce=0.
REQ-030 When undefined, REQ-023 periodic wrap SHALL apply to all directions and out_bounce SHALL be tied 0.

Verification (GRID_DIM=16)
REQ-031 Node 17, col 1, out_ready=1 -> out_addr 17,18,33,16,1,34,32,0,2 on dirs 0..8; out_last only on dir 8; in_ready high again 10 cycles after acceptance.
REQ-032 Node 0, col 0, macro undefined -> 0,1,16,15,240,17,31,255,241. With the macro defined -> 0,1,16,0,0,17,0,0,0, and out_bounce=1 on dirs 3,4,6,7,8.
REQ-033 Node 255, col 15, macro undefined -> 255,240,15,254,239,0,14,238,224.
REQ-034 Node 17 with out_ready toggling 1010... -> identical sequence, and outputs hold stable across every stall cycle.
REQ-035 Node 17 with node_col=3 -> err_col=1 from the following cycle onward; out_addr for dir 1 = 20. Assert Reset_n at dir 4 -> out_valid=0 and err_col=0 immediately; node 0 is then accepted in the first cycle after release.
